// File: rtl/apb_mem_pkg.sv
// rtl/apb_mem_pkg.sv - shared types and width helpers for the APB memory slave
//
// Holds the transfer FSM state type and the byte-lane / byte-offset width
// helpers used by the top and the byte-addressable array.
package apb_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int BYTE_W = 8;

    // Number of byte lanes in one data word.
    function automatic int lanes_of(input int data_width);
        return data_width / BYTE_W;
    endfunction

    // Number of low paddr bits that select a byte within a word.
    function automatic int offset_w_of(input int data_width);
        return $clog2(data_width / BYTE_W);
    endfunction

endpackage

// File: rtl/apb_mem_bytearray.sv
// rtl/apb_mem_bytearray.sv - word array with per-byte write enables
//
// Purpose: MEM_DEPTH x DATA_WIDTH storage, synchronous byte-masked write,
// combinational read. Contents are not reset.
// Ports:
//   clk_i      clock
//   byte_we_i  per-lane write enable (LANES bits)
//   waddr_i    write word index
//   wdata_i    write data
//   raddr_i    read word index
//   rdata_o    read data (combinational)
module apb_mem_bytearray
    import apb_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int IDX_W      = 8
) (
    input  logic                          clk_i,
    input  logic [DATA_WIDTH/BYTE_W-1:0]  byte_we_i,
    input  logic [IDX_W-1:0]              waddr_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic [IDX_W-1:0]              raddr_i,
    output logic [DATA_WIDTH-1:0]         rdata_o
);

    localparam int LANES = lanes_of(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LANES; i++) begin
            if (byte_we_i[i]) begin
                mem_q[waddr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB memory slave with programmable wait states
//
// Purpose: APB completer backed by a byte-writable word array. Each transfer
// is latched at setup, held for wait_cfg access cycles, then completed with
// pready (and pslverr for out-of-range or misaligned addresses).
// Ports:
//   clk, rstn                   clock, synchronous active-low reset
//   psel, penable, pwrite       APB control
//   paddr, pwdata, pstrb        APB address, write data, write byte strobes
//   wait_cfg                    wait states for the next transfer
//   prdata, pready, pslverr     registered APB response
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_DEPTH  = 256,
    parameter int WAIT_W     = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_WIDTH-1:0]        paddr,
    input  logic [DATA_WIDTH-1:0]        pwdata,
    input  logic [DATA_WIDTH/BYTE_W-1:0] pstrb,
    input  logic [WAIT_W-1:0]            wait_cfg,
    output logic [DATA_WIDTH-1:0]        prdata,
    output logic                         pready,
    output logic                         pslverr
);

    localparam int LANES = lanes_of(DATA_WIDTH);
    localparam int OFF_W = offset_w_of(DATA_WIDTH);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);

    state_e                  state_q, state_d;
    logic [WAIT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [LANES-1:0]        pstrb_q, pstrb_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;

    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    addr_err;
    logic                    setup;
    logic                    wr_commit;
    logic [LANES-1:0]        byte_we;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    // Address decode on the live bus; only meaningful in the setup cycle.
    assign word_addr = paddr >> OFF_W;
    assign addr_err  = (32'(word_addr) >= 32'(MEM_DEPTH)) || ((paddr & OFF_MASK) != '0);
    assign setup     = psel && !penable;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                // penable without a preceding setup is not a transfer.
                if (setup) begin
                    idx_d    = word_addr[IDX_W-1:0];
                    pwrite_d = pwrite;
                    pwdata_d = pwdata;
                    pstrb_d  = pstrb;
                    err_d    = addr_err;
                    cnt_d    = wait_cfg;
                    state_d  = (wait_cfg == '0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                    if (cnt_q == WAIT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Response registers are loaded from the next-state view so that
        // pready/pslverr/prdata are valid exactly while state_q == ST_DONE.
        pready_d  = (state_d == ST_DONE);
        pslverr_d = (state_d == ST_DONE) && err_d;
        prdata_d  = (state_d == ST_DONE && !pwrite_d && !err_d) ? mem_rdata : '0;
    end

    // The write lands on the edge leaving DONE, and only if the master still
    // holds the access phase; a reset on that edge suppresses it.
    assign wr_commit = rstn && (state_q == ST_DONE) && psel && penable && pwrite_q && !err_q;
    assign byte_we   = pstrb_q & {LANES{wr_commit}};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    apb_mem_bytearray #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk_i     (clk),
        .byte_we_i (byte_we),
        .waddr_i   (idx_q),
        .wdata_i   (pwdata_q),
        .raddr_i   (idx_d),
        .rdata_o   (mem_rdata)
    );

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - scoreboard bench for apb_mem_slave
module tb_apb_mem_slave;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 256;
    localparam int WW    = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [3:0]    pstrb = '0;
    logic [WW-1:0] wait_cfg = '0;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    always #5 clk = ~clk;

    apb_mem_slave #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (DEPTH),
        .WAIT_W     (WW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .wait_cfg (wait_cfg),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [DEPTH];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_bad(input logic [11:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    endfunction

    // Monitor: pops one expected response per pready; outside a completion
    // the response outputs must read as zero.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (pready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pready: got 1 expected 0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("prdata", prdata, e.rdata);
                    chk("pslverr", {31'd0, pslverr}, {31'd0, e.err});
                end
            end else begin
                chk("idle_prdata", prdata, 32'd0);
                chk("idle_pslverr", {31'd0, pslverr}, 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        psel = 1'b0;
        penable = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One complete transfer; returns one cycle after the DONE cycle so the
    // next call starts its setup with no dead cycle.
    task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [3:0] wt);
        exp_t e;
        int   cyc;
        e.err   = addr_bad(a);
        e.rdata = (wr || e.err) ? 32'd0 : model[a >> 2];
        if (wr && !e.err) begin
            for (int i = 0; i < 4; i++) begin
                if (st[i]) model[a >> 2][i*8 +: 8] = wd[i*8 +: 8];
            end
        end
        exp_q.push_back(e);

        psel = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = a;
        pwdata = wd;
        pstrb = st;
        wait_cfg = wt;
        @(posedge clk);
        #1;
        penable = 1'b1;
        // Bus fields other than control may wander once the setup is taken.
        paddr = 12'($urandom);
        pwdata = $urandom;
        pstrb = 4'($urandom);
        wait_cfg = 4'($urandom);
        cyc = 1;
        while (!pready && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(wt) + 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] a;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready", {31'd0, pready}, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        rstn = 1'b1;
        mon_en = 1;
        idle(1);

        // Fill the whole array so every later read has a defined value.
        for (int i = 0; i < DEPTH; i++) xfer(1, 12'(i * 4), $urandom, 4'hF, 4'd0);
        idle(1);

        // Basic write/read and wait states
        xfer(1, 12'h010, 32'hDEADBEEF, 4'hF, 4'd0);
        xfer(0, 12'h010, 32'h0, 4'h0, 4'd0);
        xfer(0, 12'h010, 32'h0, 4'h0, 4'd3);
        idle(2);

        // Byte strobes
        xfer(1, 12'h020, 32'h11223344, 4'hF, 4'd0);
        xfer(1, 12'h020, 32'hAABBCCDD, 4'h5, 4'd1);
        xfer(0, 12'h020, 32'h0, 4'hA, 4'd0);
        idle(1);

        // Error transfers
        xfer(1, 12'h400, 32'hCAFEF00D, 4'hF, 4'd0);
        xfer(0, 12'h011, 32'h0, 4'h0, 4'd2);
        xfer(1, 12'h013, 32'h12345678, 4'hF, 4'd0);
        xfer(0, 12'h000, 32'h0, 4'h0, 4'd0);
        xfer(0, 12'h010, 32'h0, 4'h0, 4'd0);
        idle(1);

        // penable without setup is ignored
        psel = 1'b1;
        penable = 1'b1;
        pwrite = 1'b1;
        paddr = 12'h010;
        pwdata = 32'hBAD0BAD0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        idle(1);
        xfer(0, 12'h010, 32'h0, 4'h0, 4'd0);
        idle(1);

        // psel dropped in the 2nd wait cycle
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 12'h030;
        pwdata = 32'h55;
        pstrb = 4'hF;
        wait_cfg = 4'd5;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        psel = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_pready", {31'd0, pready}, 32'd0);
        idle(6);
        xfer(0, 12'h030, 32'h0, 4'h0, 4'd0);
        idle(1);

        // Reset asserted mid-wait
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 12'h030;
        pwdata = 32'h55;
        pstrb = 4'hF;
        wait_cfg = 4'd5;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_pready", {31'd0, pready}, 32'd0);
        chk("midrst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("midrst_prdata", prdata, 32'd0);
        rstn = 1'b1;
        idle(6);
        xfer(0, 12'h030, 32'h0, 4'h0, 4'd0);
        idle(1);

        // Back-to-back writes then reads
        xfer(1, 12'h000, 32'h0A0A0A0A, 4'hF, 4'd0);
        xfer(1, 12'h004, 32'h1B1B1B1B, 4'hF, 4'd0);
        xfer(1, 12'h008, 32'h2C2C2C2C, 4'hF, 4'd0);
        xfer(0, 12'h000, 32'h0, 4'h0, 4'd0);
        xfer(0, 12'h004, 32'h0, 4'h0, 4'd0);
        xfer(0, 12'h008, 32'h0, 4'h0, 4'd0);
        idle(1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) a = 12'($urandom);
            else a = 12'($urandom_range(0, DEPTH - 1) << 2);
            xfer(1'($urandom), a, $urandom, 4'($urandom), 4'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 Parameter DATA_WIDTH, 32: pwdata/prdata width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, 12: byte-address width of paddr.
REQ-003 Parameter MEM_DEPTH, 256: number of DATA_WIDTH words implemented.
REQ-004 Parameter WAIT_W, 4: width of wait_cfg.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rstn  in  1  reset, synchronous, active-low.
REQ-007 psel, penable, pwrite  in  1 each  APB select, enable, direction (1=write).
REQ-008 paddr  in  ADDR_WIDTH  byte address.
REQ-009 pwdata  in  DATA_WIDTH  write data.
REQ-010 pstrb  in  DATA_WIDTH/8  write byte-lane enables.
REQ-011 wait_cfg  in  WAIT_W  wait states inserted per transfer.
REQ-012 prdata  out  DATA_WIDTH  read data, registered.
REQ-013 pready  out  1  transfer completion.
REQ-014 pslverr  out  1  transfer error, valid only with pready.

Function
REQ-015 Word index = paddr >> log2(DATA_WIDTH/8); address is erroneous if index >= MEM_DEPTH or any low byte-offset bit is nonzero.
REQ-016 FSM states IDLE, WAIT, DONE; pready = (state==DONE), a registered Moore decode.
REQ-017 IDLE: on psel & !penable (setup), latch paddr, pwrite, pwdata, pstrb, error flag; load counter with wait_cfg; go to DONE if wait_cfg==0, else WAIT.
REQ-018 IDLE with penable high and no prior setup: ignored, stay IDLE, pready 0.
REQ-019 WAIT: counter decrements each cycle; transition to DONE on the edge where counter==1.
REQ-020 Latency: with wait_cfg=N, pready rises in access cycle N+1 (N=0 gives standard two-cycle APB transfer).
REQ-021 DONE: always return to IDLE next edge; a setup presented in that following cycle is accepted (back-to-back, no dead cycle).
REQ-022 Write commits on the DONE-state edge when psel & penable & !error: byte lane i of the word updated iff pstrb[i]; other lanes unchanged.
REQ-023 Read: prdata loaded from mem[index] on the edge entering DONE; prdata = 0 in every other state and on error.
REQ-024 Error transfer: pslverr=1 during DONE, no memory change, prdata=0; pslverr=0 in all other cycles.
REQ-025 psel dropped while in WAIT or DONE: abort, go IDLE, no write, pready deasserted next cycle.
REQ-026 wait_cfg, paddr, pwdata, pstrb changes after setup SHALL NOT affect the transfer in flight.
REQ-027 pstrb ignored on reads.

Reset
REQ-028 rstn low at a rising edge: state IDLE, counter 0, pready 0, pslverr 0, prdata 0.
REQ-029 Reset mid-transfer aborts it with no memory write.
REQ-030 Memory contents not reset; undefined until written.

Structure
REQ-031 Package apb_mem_pkg holds the FSM state type and byte-lane/offset width localparams.
REQ-032 One sub-module apb_mem_bytearray: MEM_DEPTH x DATA_WIDTH array, per-byte write enable, synchronous write, combinational read.
REQ-033 Top contains FSM, wait counter, address decode/error logic, output registers; target 120-400 lines RTL total.

Verification
REQ-034 wait_cfg=0, write 0xDEADBEEF to 0x010, pstrb=0xF, then read 0x010 -> pready in first access cycle each, prdata=0xDEADBEEF, pslverr=0.
REQ-035 wait_cfg=3, read 0x010 -> pready low for 3 access cycles, high in 4th with prdata=0xDEADBEEF.
REQ-036 Write 0x11223344 to 0x020 pstrb=0xF, then 0xAABBCCDD pstrb=0x5, read 0x020 -> 0x11BB33DD.
REQ-037 Write to 0x400 (index 256) and read from 0x011 (misaligned) -> pslverr=1 with pready, prdata=0, mem[0] unchanged.
REQ-038 wait_cfg=5, write 0x55 to 0x030, drop psel in 2nd wait cycle, then read 0x030 -> previous contents returned; repeat with rstn low mid-wait -> outputs 0 next cycle, no write.
REQ-039 Back-to-back writes to 0x000, 0x004, 0x008 with no idle cycles, wait_cfg=0 -> each completes in 2 cycles, reads return all three values.
